// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the SPI mode-3 receive slave: FSM encoding and parameter defaults.
package spi_slave_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO; pointers carry one extra wrap bit for full/empty.
module spi_rx_fifo
  import spi_slave_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Caller only pushes a full FIFO when it pops in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-3 receive-only slave with synchronized inputs and a valid/ready output stage.
// Define SPI_RX_FIFO_EN to replace the single output register with a spi_rx_fifo buffer.
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, mosi_s, ss_s, sclk_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_prev_q & sclk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '1;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q, byte_q;
  logic              done_q, frame_err_q, overrun_q;

  // Deselect is tested before the sclk edge so a coincident edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          shift_q <= '0;
          if (!ss_s) state_q <= SHIFT;
        end
        SHIFT: begin
          if (ss_s) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= (cnt_q != '0);
          end else if (sclk_rise) begin
            shift_q <= {shift_q[DATA_W-2:0], mosi_s};
            if (cnt_q == CNT_LAST) begin
              cnt_q  <= '0;
              byte_q <= {shift_q[DATA_W-2:0], mosi_s};
              done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_RX_FIFO_EN
  logic fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign fifo_pop  = ~fifo_empty & rx_ready;
  assign fifo_push = done_q & (~fifo_full | fifo_pop);

  spi_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (byte_q),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (rx_data)
  );

  assign rx_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= done_q & fifo_full & ~fifo_pop;
  end
`else
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // A completing byte may replace the held one only when it is being accepted.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (done_q && (!valid_q || rx_ready)) begin
      data_d  = byte_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= done_q & valid_q & ~rx_ready;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
`endif

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
